// File: rtl/cp0_pkg.sv
// Shared encodings for the next-PC sequencer: npc_sel codes, CP0 register
// numbers, Status register field positions and the sequencer state enum.
package cp0_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_J    = 3'b001;
  localparam logic [2:0] NPC_JR   = 3'b010;
  localparam logic [2:0] NPC_BEQ  = 3'b011;
  localparam logic [2:0] NPC_ERET = 3'b100;
  localparam logic [2:0] NPC_INT  = 3'b101;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IM_MSB  = 15;

  // Only IM, EXL and IE are implemented; every other SR bit reads as zero.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  typedef enum logic {
    RUN = 1'b0,
    IRQ = 1'b1
  } state_e;

endpackage

// File: rtl/pc_seq_if.sv
// Bus between the main control FSM / datapath and the next-PC sequencer.
// Handshake: none; instr_done is a single-cycle qualifier and all outputs are per-cycle levels.
interface pc_seq_if;
  import cp0_pkg::*;

  logic        instr_done;
  logic [2:0]  br_type;
  logic [31:0] pc;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [2:0]  npc_sel;
  logic        pc_wr;
  logic [31:0] epc;
  logic        busy;
  logic        int_taken;
  state_e      state_dbg;

  modport master (
    output instr_done, br_type, pc, hw_int, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, npc_sel, pc_wr, epc, busy, int_taken, state_dbg
  );

  modport slave (
    input  instr_done, br_type, pc, hw_int, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, npc_sel, pc_wr, epc, busy, int_taken, state_dbg
  );

endinterface

// File: rtl/cp0_regs.sv
// CP0 interrupt state: SR, Cause.IP, EPC and PRId storage, mtc0/mfc0 access
// and the pending-interrupt equation built from registered values only.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  hw_int,
  input  logic [31:0] pc,
  input  logic        eret_clr,
  input  logic        hw_save,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc,
  output logic        irq
);

  logic [31:0] sr_q, sr_d;
  logic [5:0]  ip_q, ip_d;
  logic [31:0] epc_q, epc_d;

  // Later assignments override earlier ones: the hardware save beats both
  // the eret clear and any mtc0 landing in the same cycle.
  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    ip_d  = hw_int;
    if (cp0_we && cp0_addr == CP0_SR)  sr_d  = cp0_wdata & SR_WMASK;
    if (cp0_we && cp0_addr == CP0_EPC) epc_d = cp0_wdata;
    if (eret_clr) sr_d[SR_EXL_BIT] = 1'b0;
    if (hw_save) begin
      sr_d[SR_EXL_BIT] = 1'b1;
      epc_d            = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      ip_q  <= '0;
      epc_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = sr_q;
      CP0_CAUSE: cp0_rdata = {16'h0000, ip_q, 10'b00_0000_0000};
      CP0_EPC:   cp0_rdata = epc_q;
      CP0_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = '0;
    endcase
  end

  assign epc = epc_q;
  assign irq = (|(ip_q & sr_q[SR_IM_MSB:SR_IM_LSB])) & sr_q[SR_IE_BIT] & ~sr_q[SR_EXL_BIT];

endmodule

// File: rtl/pc_seq.sv
// Next-PC sequencer: picks the PC source at each instruction boundary and
// inserts a one-cycle vector redirect when an enabled interrupt is pending.
module pc_seq
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0001
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.slave  bus
);

  state_e      state_q, state_d;
  logic        irq;
  logic        eret_clr;
  logic        hw_save;
  logic [2:0]  npc_sel;
  logic        pc_wr;
  logic        busy;
  logic        int_taken;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;

  cp0_regs #(.PRID(PRID)) u_cp0_regs (
    .clk       (clk),
    .rst       (rst),
    .cp0_we    (bus.cp0_we),
    .cp0_addr  (bus.cp0_addr),
    .cp0_wdata (bus.cp0_wdata),
    .hw_int    (bus.hw_int),
    .pc        (bus.pc),
    .eret_clr  (eret_clr),
    .hw_save   (hw_save),
    .cp0_rdata (cp0_rdata),
    .epc       (epc),
    .irq       (irq)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // The normal PC update at a boundary still happens when irq is seen;
  // the vector redirect follows in the IRQ cycle with pc already advanced.
  always_comb begin
    state_d   = state_q;
    npc_sel   = NPC_SEQ;
    pc_wr     = 1'b0;
    busy      = 1'b0;
    int_taken = 1'b0;
    eret_clr  = 1'b0;
    hw_save   = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.instr_done) begin
            pc_wr    = 1'b1;
            npc_sel  = bus.br_type;
            eret_clr = (bus.br_type == NPC_ERET);
            if (irq) state_d = IRQ;
          end
        end
        IRQ: begin
          busy      = 1'b1;
          int_taken = 1'b1;
          pc_wr     = 1'b1;
          npc_sel   = NPC_INT;
          hw_save   = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.npc_sel   = npc_sel;
  assign bus.pc_wr     = pc_wr;
  assign bus.busy      = busy;
  assign bus.int_taken = int_taken;
  assign bus.cp0_rdata = cp0_rdata;
  assign bus.epc       = epc;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: boundary decode, interrupt entry/return,
// masking, simultaneous-write priority and reset during the vector cycle.
module tb_pc_seq;
  import cp0_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_seq_if bus ();

  pc_seq #(.PRID(32'h0000_0001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are always changed at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.instr_done = 1'b0;
    bus.br_type    = 3'b000;
    bus.cp0_we     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    check(tag, bus.cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
    step();
    bus.cp0_we    = 1'b0;
  endtask

  task automatic outs_check(input string tag, input logic [2:0] sel, input logic wr,
                            input logic bsy, input logic tkn);
    #1;
    check({tag, ".npc_sel"},   32'(bus.npc_sel),   32'(sel));
    check({tag, ".pc_wr"},     32'(bus.pc_wr),     32'(wr));
    check({tag, ".busy"},      32'(bus.busy),      32'(bsy));
    check({tag, ".int_taken"}, 32'(bus.int_taken), 32'(tkn));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.pc        = 32'h0000_3000;
    bus.hw_int    = 6'b000000;
    bus.cp0_addr  = 5'd0;
    bus.cp0_wdata = 32'h0;
    idle();
    bus.instr_done = 1'b1;
    @(negedge clk);
    outs_check("rst_hold", 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    idle();

    // Plain sequential boundary and reset register values
    bus.instr_done = 1'b1;
    outs_check("seq", NPC_SEQ, 1'b1, 1'b0, 1'b0);
    read_check("rst_sr", CP0_SR, 32'h0);
    read_check("rst_cause", CP0_CAUSE, 32'h0);
    read_check("rst_epc", CP0_EPC, 32'h0);
    read_check("prid", CP0_PRID, 32'h0000_0001);
    read_check("unmapped", 5'd3, 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'(RUN));
    step();
    idle();

    // Interrupt entry: IM[0] and IE set, hw_int[0] raised
    bus.hw_int = 6'b000001;
    mtc0(5'd3, 32'hFFFF_FFFF);
    read_check("unmapped_wr", 5'd3, 32'h0);
    mtc0(CP0_SR, 32'h0000_0401);
    read_check("cause_ip", CP0_CAUSE, 32'h0000_0400);
    bus.instr_done = 1'b1;
    bus.pc         = 32'h0000_3010;
    outs_check("irq_bnd", NPC_SEQ, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    outs_check("irq_cyc", NPC_INT, 1'b1, 1'b1, 1'b1);
    check("irq_state", 32'(bus.state_dbg), 32'(IRQ));
    step();
    outs_check("post_irq", NPC_SEQ, 1'b0, 1'b0, 1'b0);
    read_check("epc_saved", CP0_EPC, 32'h0000_3010);
    read_check("sr_exl", CP0_SR, 32'h0000_0403);

    // eret while hw_int still high: EXL masks, no IRQ follows
    bus.pc         = 32'h0000_4180;
    bus.instr_done = 1'b1;
    bus.br_type    = NPC_ERET;
    outs_check("eret", NPC_ERET, 1'b1, 1'b0, 1'b0);
    check("eret_epc", bus.epc, 32'h0000_3010);
    step();
    idle();
    outs_check("eret_after", NPC_SEQ, 1'b0, 1'b0, 1'b0);
    read_check("sr_exl_clr", CP0_SR, 32'h0000_0401);

    // Next boundary takes it; mtc0 EPC in the IRQ cycle is dropped
    bus.pc         = 32'h0000_3020;
    bus.instr_done = 1'b1;
    step();
    idle();
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = CP0_EPC;
    bus.cp0_wdata = 32'hDEAD_BEEF;
    outs_check("retake", NPC_INT, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    read_check("epc_hw_wins", CP0_EPC, 32'h0000_3020);

    // mtc0 SR clearing EXL in the IRQ cycle loses to the hardware set
    mtc0(CP0_SR, 32'h0000_0401);
    bus.instr_done = 1'b1;
    step();
    idle();
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = CP0_SR;
    bus.cp0_wdata = 32'h0000_0401;
    outs_check("exl_race", NPC_INT, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    read_check("exl_hw_wins", CP0_SR, 32'h0000_0403);

    // IE clear: boundary must not enter IRQ
    mtc0(CP0_SR, 32'h0000_0400);
    bus.instr_done = 1'b1;
    step();
    idle();
    outs_check("ie_off", NPC_SEQ, 1'b0, 1'b0, 1'b0);
    check("ie_off_state", 32'(bus.state_dbg), 32'(RUN));

    // Flow classes driven straight through
    bus.instr_done = 1'b1;
    bus.br_type    = NPC_JR;
    outs_check("jr", NPC_JR, 1'b1, 1'b0, 1'b0);
    step();
    bus.br_type = NPC_BEQ;
    outs_check("beq", NPC_BEQ, 1'b1, 1'b0, 1'b0);
    step();
    bus.br_type = 3'b110;
    outs_check("br110", 3'b110, 1'b1, 1'b0, 1'b0);
    step();
    idle();

    // Reset asserted during the IRQ cycle
    mtc0(CP0_SR, 32'h0000_0401);
    bus.pc         = 32'h0000_5000;
    bus.instr_done = 1'b1;
    step();
    idle();
    check("pre_rst_irq", 32'(bus.state_dbg), 32'(IRQ));
    rst = 1'b1;
    outs_check("rst_in_irq", NPC_SEQ, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    check("rst_irq_state", 32'(bus.state_dbg), 32'(RUN));
    outs_check("rst_irq_out", NPC_SEQ, 1'b0, 1'b0, 1'b0);
    read_check("rst_irq_epc", CP0_EPC, 32'h0);
    read_check("rst_irq_sr", CP0_SR, 32'h0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Sequencer for the next-PC unit of the multi-cycle MIPS core.
- At each instruction boundary it decides whether the PC advances sequentially, branches, jumps, returns from exception, or is redirected to the interrupt vector 0x0000_4180.
- Drives the next-PC select code and the PC write enable.
- Also holds the CP0 interrupt state (SR, Cause, EPC, PRId) and arbitrates six hardware interrupt lines against instruction flow.

Parameters:
PRID, 32'h0000_0001, value returned on reads of CP0 register 15

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
instr_done  input  1  main control FSM is in the final cycle of the current instruction
br_type  input  3  decoded flow class: 000 seq, 001 j/jal, 010 jr, 011 beq, 100 eret
pc  input  32  current PC register value
hw_int  input  6  level-sensitive hardware interrupt requests
cp0_we  input  1  mtc0 write strobe
cp0_addr  input  5  CP0 register number for mtc0/mfc0
cp0_wdata  input  32  mtc0 data
cp0_rdata  output  32  mfc0 data, combinational from cp0_addr
npc_sel  output  3  next-PC select: 000 pc+4, 001 j, 010 jr, 011 beq, 100 eret, 101 interrupt
pc_wr  output  1  PC register load enable
epc  output  32  EPC value, drives the next-PC eret address
busy  output  1  high in IRQ state; main FSM holds in fetch
int_taken  output  1  one-cycle pulse on the vector redirect cycle

Behaviour:
- Reset (rst high at clk edge): state=RUN, SR=0, Cause=0, EPC=0.
  - While rst is high: pc_wr=0, npc_sel=000, busy=0, int_taken=0.
- CP0 registers:
  - SR (12): bits[15:10] IM, bit[1] EXL, bit[0] IE; other bits read 0.
  - Cause (13): bits[15:10] IP, loaded from hw_int every cycle (one-cycle registered); read-only; other bits 0.
  - EPC (14): read/write, all 32 bits.
  - PRId (15): PRID, read-only.
  - Other addresses read 0; writes to them are ignored.
- Pending interrupt: irq = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL, evaluated from registered values only.
- RUN state:
  - instr_done=0: pc_wr=0, npc_sel=000.
  - instr_done=1: pc_wr=1, npc_sel=br_type.
  - If br_type=100 (eret): EXL<=0 at the clock edge.
  - If irq=1 at instr_done: the normal PC update still happens this cycle, and the next state is IRQ.
- IRQ state (exactly one cycle):
  - busy=1, int_taken=1, pc_wr=1, npc_sel=101.
  - EPC<=pc, which is the address of the first unexecuted instruction.
  - EXL<=1.
  - Next state is RUN.
  - instr_done is ignored in this state.
- Latency: interrupt entry takes 1 extra cycle after the boundary. Handler fetch begins the cycle after IRQ.
- Simultaneous events:
  - mtc0 to SR on the same cycle as an instr_done that samples irq: the decision uses the pre-write SR; the write takes effect at the edge.
  - mtc0 to EPC in the IRQ cycle: the hardware save wins and the mtc0 is dropped.
  - eret with irq pending: irq is masked because the registered EXL=1. The interrupt is taken at the next boundary after EXL clears.
  - mtc0 write to SR.EXL in the IRQ cycle: the hardware set wins.
- A hw_int pulse shorter than one cycle may be missed. Interrupts are level-sensitive and must be held until software acknowledges them.
- br_type values 101-111 in RUN are driven through as-is; the next-PC unit maps them to 0x0000_3000.
- Reset asserted mid-IRQ: returns to RUN without updating EPC.

Decomposition:
- Shared package (cp0_pkg) holds:
  - npc_sel encodings (NPC_SEQ, NPC_J, NPC_JR, NPC_BEQ, NPC_ERET, NPC_INT).
  - CP0 register numbers (CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15).
  - SR field bit positions.
  - The state enum {RUN, IRQ}.
- One natural sub-module, cp0_regs: SR/Cause/EPC/PRId storage, mtc0/mfc0 and the irq equation.
- pc_seq keeps the FSM and output decode.

Test Plan:
- Reset then instr_done=1, br_type=000 → pc_wr=1, npc_sel=000; SR, Cause and EPC all read 0.
- mtc0 SR=32'h0000_0401, hw_int[0]=1, instr_done=1 with pc=0x3010 → that cycle npc_sel=000.
  - Next cycle: busy=1, int_taken=1, npc_sel=101, pc_wr=1.
  - Afterwards EPC=0x3010 and SR reads 0x0000_0403.
- Same setup with SR.IE=0 → no IRQ cycle; busy stays 0.
- In handler (EXL=1), hw_int still high, instr_done with br_type=100 → npc_sel=100, epc=0x3010, no IRQ state.
  - Next boundary (EXL=0, hw_int still high) → IRQ taken.
- Drive instr_done with br_type=010 and br_type=011 → npc_sel is 010 and 011 respectively, each with pc_wr=1.
- Assert rst during the IRQ cycle → next cycle state=RUN, EPC and SR both 0, pc_wr=0.
